// File: rtl/vga_capture_module_pkg.sv
// Shared types and default VGA timing for the capture path.
// The generator uses the same timing defaults.
package vga_capture_module_pkg;

  localparam int unsigned DEF_D_WIDTH  = 8;
  localparam int unsigned DEF_P_WIDTH  = 10;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_A_WIDTH  = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } cap_state_t;

endpackage

// File: rtl/vga_sync_edge_module.sv
// Input stage: registers the VGA stream once, normalises sync polarity
// so that 1 = asserted, and flags sync edges on the registered copies.
module vga_sync_edge_module
  import vga_capture_module_pkg::*;
#(
  parameter int unsigned D_WIDTH  = DEF_D_WIDTH,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [D_WIDTH-1:0]   vga_r,
  input  logic [D_WIDTH-1:0]   vga_g,
  input  logic [D_WIDTH-1:0]   vga_b,
  input  logic                 vga_hs,
  input  logic                 vga_vs,
  output logic [3*D_WIDTH-1:0] pix,
  output logic                 hs_end_c,
  output logic                 vs_start_c,
  output logic                 vs_end_c
);

  logic hs_q;
  logic vs_q;
  logic hs_d;
  logic vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      pix  <= {vga_r, vga_g, vga_b};
      hs_q <= (vga_hs == SYNC_POL);
      vs_q <= (vga_vs == SYNC_POL);
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  // Edges line up with the pixel currently held in pix.
  assign hs_end_c   = hs_d & ~hs_q;
  assign vs_start_c = ~vs_d & vs_q;
  assign vs_end_c   = vs_d & ~vs_q;

endmodule

// File: rtl/vga_capture_module.sv
// Captures one active VGA frame into a BRAM write port on request,
// recovering pixel coordinates from sync edges and checking line length.
module vga_capture_module
  import vga_capture_module_pkg::*;
#(
  parameter int unsigned D_WIDTH  = DEF_D_WIDTH,
  parameter int unsigned P_WIDTH  = DEF_P_WIDTH,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned A_WIDTH  = DEF_A_WIDTH
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [D_WIDTH-1:0]   VGA_R,
  input  logic [D_WIDTH-1:0]   VGA_G,
  input  logic [D_WIDTH-1:0]   VGA_B,
  input  logic                 VGA_HS,
  input  logic                 VGA_VS,
  input  logic                 ARM,
  output logic [A_WIDTH-1:0]   BRAM_ADDR,
  output logic [3*D_WIDTH-1:0] BRAM_DIN,
  output logic                 BRAM_WE,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic                 LINE_ERR,
  output logic                 FRAME_ERR
);

  localparam int unsigned C_WIDTH = P_WIDTH + 1;
  localparam int unsigned N_PIX   = H_ACTIVE * V_ACTIVE;
  localparam logic [C_WIDTH-1:0] C_MAX = '1;

  logic [3*D_WIDTH-1:0] pix;
  logic                 hs_end_c;
  logic                 vs_start_c;
  logic                 vs_end_c;

  vga_sync_edge_module #(
    .D_WIDTH  (D_WIDTH),
    .SYNC_POL (SYNC_POL)
  ) u_sync_edge (
    .clk        (CLOCK_50),
    .reset      (RESET),
    .vga_r      (VGA_R),
    .vga_g      (VGA_G),
    .vga_b      (VGA_B),
    .vga_hs     (VGA_HS),
    .vga_vs     (VGA_VS),
    .pix        (pix),
    .hs_end_c   (hs_end_c),
    .vs_start_c (vs_start_c),
    .vs_end_c   (vs_end_c)
  );

  cap_state_t           state;
  logic [C_WIDTH-1:0]   hcnt_q;
  logic [C_WIDTH-1:0]   vcnt_q;
  logic [C_WIDTH-1:0]   hcnt_c;
  logic [C_WIDTH-1:0]   vcnt_c;
  logic                 have_ref;
  logic                 last_wr;
  logic [A_WIDTH-1:0]   next_addr;
  logic [A_WIDTH-1:0]   addr_q;
  logic [3*D_WIDTH-1:0] din_q;
  logic                 we_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 line_err_q;
  logic                 frame_err_q;
  logic                 pix_active_c;
  logic                 line_bad_c;
  logic                 last_pix_c;

  // Coordinates of the pixel currently held in the input stage; saturating.
  always_comb begin
    hcnt_c = hcnt_q;
    vcnt_c = vcnt_q;
    if (hs_end_c) begin
      hcnt_c = '0;
    end else if (hcnt_q != C_MAX) begin
      hcnt_c = hcnt_q + C_WIDTH'(1);
    end
    if (vs_end_c) begin
      vcnt_c = '0;
    end else if (hs_end_c && (vcnt_q != C_MAX)) begin
      vcnt_c = vcnt_q + C_WIDTH'(1);
    end
  end

  always_comb begin
    pix_active_c = (hcnt_c >= C_WIDTH'(H_BP)) &&
                   (hcnt_c <  C_WIDTH'(H_BP + H_ACTIVE)) &&
                   (vcnt_c >= C_WIDTH'(V_BP)) &&
                   (vcnt_c <  C_WIDTH'(V_BP + V_ACTIVE));
    // hcnt_q holds the index of the last clock of the line just ended.
    line_bad_c   = hs_end_c && have_ref && (hcnt_q != C_WIDTH'(H_TOTAL - 1));
    last_pix_c   = (next_addr == A_WIDTH'(N_PIX - 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state       <= ST_IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      have_ref    <= 1'b0;
      last_wr     <= 1'b0;
      next_addr   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_c;
      vcnt_q <= vcnt_c;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (hs_end_c) begin
        have_ref <= 1'b1;
      end
      if (line_bad_c) begin
        line_err_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (ARM) begin
            state       <= ST_ARMED;
            busy_q      <= 1'b1;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            have_ref    <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (vs_end_c) begin
            state     <= ST_CAPTURE;
            addr_q    <= '0;
            next_addr <= '0;
            last_wr   <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          if (last_wr) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            last_wr <= 1'b0;
          end else if (line_bad_c || vs_start_c) begin
            // Partial frame is dropped; wait for the next frame start.
            state <= ST_ARMED;
            if (vs_start_c) begin
              frame_err_q <= 1'b1;
            end
          end else if (pix_active_c) begin
            we_q      <= 1'b1;
            din_q     <= pix;
            addr_q    <= next_addr;
            next_addr <= next_addr + A_WIDTH'(1);
            last_wr   <= last_pix_c;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign BRAM_ADDR  = addr_q;
  assign BRAM_DIN   = din_q;
  assign BRAM_WE    = we_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign LINE_ERR   = line_err_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_vga_capture_module.sv
// Directed bench for vga_capture_module using a small 16x8 VGA timing
// (8x4 active) with colour = x coordinate.
module tb_vga_capture_module;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 10;
  localparam int unsigned AW = 6;
  localparam int unsigned EW = AW + 3 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] r, g, b;
  logic          hs_raw, vs_raw, arm;

  logic [AW-1:0]   addr0, addr1;
  logic [3*DW-1:0] din0, din1;
  logic we0, we1, busy0, busy1, done0, done1, lerr0, lerr1, ferr0, ferr1;

  vga_capture_module #(
    .D_WIDTH(DW), .P_WIDTH(PW), .H_ACTIVE(8), .H_BP(2), .H_TOTAL(16),
    .V_ACTIVE(4), .V_BP(1), .SYNC_POL(1'b0), .A_WIDTH(AW)
  ) dut0 (
    .CLOCK_50(clk), .RESET(rst), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs_raw), .VGA_VS(vs_raw), .ARM(arm),
    .BRAM_ADDR(addr0), .BRAM_DIN(din0), .BRAM_WE(we0), .BUSY(busy0),
    .FRAME_DONE(done0), .LINE_ERR(lerr0), .FRAME_ERR(ferr0)
  );

  vga_capture_module #(
    .D_WIDTH(DW), .P_WIDTH(PW), .H_ACTIVE(8), .H_BP(2), .H_TOTAL(16),
    .V_ACTIVE(4), .V_BP(1), .SYNC_POL(1'b1), .A_WIDTH(AW)
  ) dut1 (
    .CLOCK_50(clk), .RESET(rst), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(~hs_raw), .VGA_VS(~vs_raw), .ARM(arm),
    .BRAM_ADDR(addr1), .BRAM_DIN(din1), .BRAM_WE(we1), .BUSY(busy1),
    .FRAME_DONE(done1), .LINE_ERR(lerr1), .FRAME_ERR(ferr1)
  );

  int checks = 0;
  int passed = 0;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  int            done_cnt0, done_cnt1;
  bit            done_ok0;
  logic          prev_we0;
  logic [AW-1:0] prev_addr0;

  // Write/done recorder.
  always @(negedge clk) begin
    if (we0 === 1'b1) q0.push_back({addr0, din0});
    if (we1 === 1'b1) q1.push_back({addr1, din1});
    if (done0 === 1'b1) begin
      done_cnt0++;
      done_ok0 = (prev_we0 === 1'b1) && (prev_addr0 == AW'(31)) && (busy0 === 1'b0);
    end
    if (done1 === 1'b1) done_cnt1++;
    prev_we0   = we0;
    prev_addr0 = addr0;
  end

  function automatic logic [EW-1:0] exp_entry(input int i);
    logic [DW-1:0] x;
    x = DW'(i % 8);
    return {AW'(i), x, x, x};
  endfunction

  task clear_mon();
    q0.delete();
    q1.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
    done_ok0  = 1'b0;
  endtask

  // One line: HS asserted for the last 4 clocks, active x = h-2 for h in 2..9.
  task drive_line(input int len, input bit vs_asrt, input int arm_h);
    for (int h = 0; h < len; h++) begin
      hs_raw = (h >= len - 4) ? 1'b0 : 1'b1;
      vs_raw = vs_asrt ? 1'b0 : 1'b1;
      arm    = (h == arm_h);
      if (h >= 2 && h < 10) begin
        r = DW'(h - 2); g = DW'(h - 2); b = DW'(h - 2);
      end else begin
        r = '0; g = '0; b = '0;
      end
      @(negedge clk);
    end
  endtask

  task drive_frame(input int stretch_line, input int vs_from, input int arm_line, input int arm_h);
    for (int l = 0; l < 8; l++)
      drive_line((l == stretch_line) ? 17 : 16, (l >= vs_from), (l == arm_line) ? arm_h : -1);
  endtask

  task preroll(input int arm_h);
    drive_line(16, 1'b1, arm_h);
    drive_line(16, 1'b1, -1);
  endtask

  task test_reset();
    rst = 1'b1; hs_raw = 1'b1; vs_raw = 1'b1; arm = 1'b0;
    r = '0; g = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (we0 !== 1'b0) $display("FAIL reset_we: got %b want 0", we0); else passed++;
    checks++; if (addr0 !== '0) $display("FAIL reset_addr: got %0d want 0", addr0); else passed++;
    checks++; if (din0 !== '0) $display("FAIL reset_din: got %h want 0", din0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else passed++;
    checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else passed++;
    checks++; if (lerr0 !== 1'b0) $display("FAIL reset_line_err: got %b want 0", lerr0); else passed++;
    checks++; if (ferr0 !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", ferr0); else passed++;
    rst = 1'b0;
  endtask

  task test_loopback();
    clear_mon();
    preroll(5);
    drive_frame(-1, 6, -1, -1);
    checks++; if (done_cnt0 != 1) $display("FAIL loop_done_cnt: got %0d want 1", done_cnt0); else passed++;
    checks++; if (!done_ok0) $display("FAIL loop_done_timing: got %b want 1", done_ok0); else passed++;
    checks++; if (q0.size() != 32) $display("FAIL loop_wr_cnt: got %0d want 32", q0.size()); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (i >= q0.size() || q0[i] !== exp_entry(i))
        $display("FAIL loop_wr[%0d]: got %h want %h", i, (i < q0.size()) ? q0[i] : '0, exp_entry(i));
      else passed++;
    end
    checks++; if (lerr0 !== 1'b0) $display("FAIL loop_line_err: got %b want 0", lerr0); else passed++;
    checks++; if (ferr0 !== 1'b0) $display("FAIL loop_frame_err: got %b want 0", ferr0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL loop_busy: got %b want 0", busy0); else passed++;
    checks++; if (done_cnt1 != 1) $display("FAIL pol1_done_cnt: got %0d want 1", done_cnt1); else passed++;
    checks++; if (q1.size() != 32) $display("FAIL pol1_wr_cnt: got %0d want 32", q1.size()); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (i >= q1.size() || q1[i] !== exp_entry(i))
        $display("FAIL pol1_wr[%0d]: got %h want %h", i, (i < q1.size()) ? q1[i] : '0, exp_entry(i));
      else passed++;
    end
  endtask

  task test_line_err();
    clear_mon();
    preroll(5);
    drive_frame(2, 6, -1, -1);
    checks++; if (lerr0 !== 1'b1) $display("FAIL lerr_set: got %b want 1", lerr0); else passed++;
    checks++; if (busy0 !== 1'b1) $display("FAIL lerr_busy: got %b want 1", busy0); else passed++;
    checks++; if (done_cnt0 != 0) $display("FAIL lerr_no_done: got %0d want 0", done_cnt0); else passed++;
    checks++; if (q0.size() != 16) $display("FAIL lerr_partial: got %0d want 16", q0.size()); else passed++;
    drive_frame(-1, 6, -1, -1);
    checks++; if (done_cnt0 != 1) $display("FAIL lerr_next_done: got %0d want 1", done_cnt0); else passed++;
    checks++; if (q0.size() != 48) $display("FAIL lerr_total_wr: got %0d want 48", q0.size()); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (16 + i >= q0.size() || q0[16 + i] !== exp_entry(i))
        $display("FAIL lerr_wr[%0d]: got %h want %h", i, (16 + i < q0.size()) ? q0[16 + i] : '0, exp_entry(i));
      else passed++;
    end
    checks++; if (busy0 !== 1'b0) $display("FAIL lerr_busy_end: got %b want 0", busy0); else passed++;
    checks++; if (lerr0 !== 1'b1) $display("FAIL lerr_sticky: got %b want 1", lerr0); else passed++;
  endtask

  task test_frame_err();
    clear_mon();
    preroll(5);
    drive_frame(-1, 3, -1, -1);
    checks++; if (ferr0 !== 1'b1) $display("FAIL ferr_set: got %b want 1", ferr0); else passed++;
    checks++; if (lerr0 !== 1'b0) $display("FAIL ferr_line_err: got %b want 0", lerr0); else passed++;
    checks++; if (busy0 !== 1'b1) $display("FAIL ferr_busy: got %b want 1", busy0); else passed++;
    checks++; if (done_cnt0 != 0) $display("FAIL ferr_no_done: got %0d want 0", done_cnt0); else passed++;
    checks++; if (q0.size() != 16) $display("FAIL ferr_partial: got %0d want 16", q0.size()); else passed++;
    drive_frame(-1, 6, -1, -1);
    checks++; if (done_cnt0 != 1) $display("FAIL ferr_next_done: got %0d want 1", done_cnt0); else passed++;
    checks++; if (q0.size() != 48) $display("FAIL ferr_total_wr: got %0d want 48", q0.size()); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (16 + i >= q0.size() || q0[16 + i] !== exp_entry(i))
        $display("FAIL ferr_wr[%0d]: got %h want %h", i, (16 + i < q0.size()) ? q0[16 + i] : '0, exp_entry(i));
      else passed++;
    end
    checks++; if (busy0 !== 1'b0) $display("FAIL ferr_busy_end: got %b want 0", busy0); else passed++;
  endtask

  task test_arm_ignored();
    clear_mon();
    preroll(5);
    drive_frame(-1, 6, 2, 5);
    checks++; if (done_cnt0 != 1) $display("FAIL armbusy_done: got %0d want 1", done_cnt0); else passed++;
    checks++; if (q0.size() != 32) $display("FAIL armbusy_wr_cnt: got %0d want 32", q0.size()); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (i >= q0.size() || q0[i] !== exp_entry(i))
        $display("FAIL armbusy_wr[%0d]: got %h want %h", i, (i < q0.size()) ? q0[i] : '0, exp_entry(i));
      else passed++;
    end
    checks++; if (busy0 !== 1'b0) $display("FAIL armbusy_idle: got %b want 0", busy0); else passed++;
    clear_mon();
    drive_frame(-1, 6, 0, 1);
    checks++; if (q0.size() != 0) $display("FAIL armvs_no_wr: got %0d want 0", q0.size()); else passed++;
    checks++; if (busy0 !== 1'b1) $display("FAIL armvs_armed: got %b want 1", busy0); else passed++;
    checks++; if (done_cnt0 != 0) $display("FAIL armvs_no_done: got %0d want 0", done_cnt0); else passed++;
    drive_frame(-1, 6, -1, -1);
    checks++; if (q0.size() != 32) $display("FAIL armvs_wr_cnt: got %0d want 32", q0.size()); else passed++;
    checks++; if (done_cnt0 != 1) $display("FAIL armvs_done: got %0d want 1", done_cnt0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL armvs_idle: got %b want 0", busy0); else passed++;
  endtask

  task test_reset_mid();
    bit hit;
    int n_before;
    clear_mon();
    preroll(5);
    hit = 1'b0;
    fork
      drive_frame(-1, 6, -1, -1);
      begin
        for (int c = 0; c < 200 && !hit; c++) begin
          @(negedge clk);
          if (we0 === 1'b1 && addr0 == AW'(9)) begin
            hit = 1'b1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (we0 !== 1'b0) $display("FAIL rstmid_we: got %b want 0", we0); else passed++;
            checks++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy0); else passed++;
            checks++; if (addr0 !== '0) $display("FAIL rstmid_addr: got %0d want 0", addr0); else passed++;
            checks++; if (din0 !== '0) $display("FAIL rstmid_din: got %h want 0", din0); else passed++;
            checks++; if (done0 !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done0); else passed++;
            @(negedge clk);
            rst = 1'b0;
          end
        end
      end
    join
    checks++; if (!hit) $display("FAIL rstmid_write10_seen: got 0 want 1"); else passed++;
    n_before = q0.size();
    checks++; if (n_before != 10) $display("FAIL rstmid_wr_before: got %0d want 10", n_before); else passed++;
    drive_frame(-1, 6, -1, -1);
    checks++; if (q0.size() != n_before) $display("FAIL rstmid_no_wr: got %0d want %0d", q0.size(), n_before); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", busy0); else passed++;
    checks++; if (done_cnt0 != 0) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt0); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loopback();
    test_line_err();
    test_frame_err();
    test_arm_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
